// File: rtl/bft_host_sink.sv
// BFT egress endpoint: buffers this leaf's packets per destination port, drains them
// round-robin onto one AXI-Stream master and returns freespace credits upstream.
module bft_host_sink #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_PORTS             = 2,
  parameter int FIFO_DEPTH_BITS       = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SELF_LEAF             = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PACKET_BITS-1:0]             din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]             dout_leaf_interface2bft,
  input  logic [NUM_PORTS*NUM_LEAF_BITS-1:0] cfg_src_leaf,
  input  logic [NUM_PORTS*NUM_PORT_BITS-1:0] cfg_src_port,
  output logic [PAYLOAD_BITS-1:0]            m_axis_tdata,
  output logic [NUM_PORT_BITS-1:0]           m_axis_tdest,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [NUM_PORTS-1:0]               overflow,
  output logic [15:0]                        drop_count
);
  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = FIFO_DEPTH_BITS + 1;
  localparam int CONS_W = $clog2(FREESPACE_UPDATE_SIZE + 1);
  localparam logic [NUM_LEAF_BITS-1:0] SELF       = NUM_LEAF_BITS'(SELF_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] MAX_PORT   = NUM_PORT_BITS'(NUM_PORTS);
  localparam logic [CNT_W-1:0]         FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CONS_W-1:0]        CREDIT_CNT = CONS_W'(FREESPACE_UPDATE_SIZE);

  logic [PAYLOAD_BITS-1:0]    mem_q [NUM_PORTS][DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q [NUM_PORTS];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q [NUM_PORTS];
  logic [CNT_W-1:0]           count_q [NUM_PORTS];
  logic [CONS_W-1:0]          cons_q [NUM_PORTS];
  logic [CONS_W-1:0]          cons_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]       pending_q, pending_d;
  logic [PTR_W-1:0]           rr_q;
  logic                       tvalid_q;
  logic [PAYLOAD_BITS-1:0]    tdata_q;
  logic [NUM_PORT_BITS-1:0]   tdest_q;
  logic [PACKET_BITS-1:0]     dout_q, dout_d;
  logic [NUM_PORTS-1:0]       ovf_q;
  logic [15:0]                drop_q;

  logic                       in_mine, in_port_ok, bad_drop;
  logic [NUM_LEAF_BITS-1:0]   in_leaf;
  logic [NUM_PORT_BITS-1:0]   in_port;
  logic [PAYLOAD_BITS-1:0]    in_payload;
  logic [NUM_PORTS-1:0]       wr_en, wr_drop, rd_en, trig;
  logic                       sel_found, cred_found, load, fire;
  logic [PTR_W-1:0]           sel_idx, cand, cred_idx;

  assign in_leaf    = din_leaf_bft2interface[PACKET_BITS-2 -: NUM_LEAF_BITS];
  assign in_port    = din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
  assign in_payload = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  assign in_mine    = din_leaf_bft2interface[PACKET_BITS-1] && (in_leaf == SELF);
  assign in_port_ok = (in_port != '0) && (in_port <= MAX_PORT);
  assign bad_drop   = in_mine && !in_port_ok;

  // Fullness uses start-of-cycle occupancy, so a same-cycle read never rescues a write.
  always_comb begin
    wr_en   = '0;
    wr_drop = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_mine && in_port_ok && in_port == NUM_PORT_BITS'(p + 1)) begin
        if (count_q[p] == FULL_CNT) wr_drop[p] = 1'b1;
        else                        wr_en[p]   = 1'b1;
      end
    end
  end

  // AXI-Stream: a beat transfers when tvalid && tready; tdata/tdest stay frozen while
  // tvalid is high and tready low. The register reloads when empty or firing.
  assign fire = tvalid_q && m_axis_tready;
  assign load = !tvalid_q || m_axis_tready;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_q) + i) % NUM_PORTS);
      if (count_q[cand] != '0) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    rd_en = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_en[p] = load && sel_found && (sel_idx == PTR_W'(p));
    end
  end

  always_comb begin
    trig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cons_d[p] = cons_q[p];
      if (fire && tdest_q == NUM_PORT_BITS'(p + 1)) begin
        cons_d[p] = cons_q[p] + 1'b1;
        if (cons_d[p] == CREDIT_CNT) begin
          cons_d[p] = '0;
          trig[p]   = 1'b1;
        end
      end
    end
  end

  // Lowest-index pending port owns the credit slot this cycle.
  always_comb begin
    cred_found = 1'b0;
    cred_idx   = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (pending_q[p]) begin
        cred_found = 1'b1;
        cred_idx   = PTR_W'(p);
      end
    end
    pending_d = pending_q | trig;
    dout_d    = '0;
    if (cred_found) begin
      pending_d[cred_idx] = trig[cred_idx];
      dout_d = {1'b1,
                cfg_src_leaf[cred_idx*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                cfg_src_port[cred_idx*NUM_PORT_BITS +: NUM_PORT_BITS],
                NUM_ADDR_BITS'(cred_idx) + NUM_ADDR_BITS'(1),
                PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en[p]) mem_q[p][wr_ptr_q[p]] <= in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
        cons_q[p]   <= '0;
      end
      pending_q <= '0;
      rr_q      <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tdest_q   <= '0;
      dout_q    <= '0;
      ovf_q     <= '0;
      drop_q    <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en[p]) wr_ptr_q[p] <= wr_ptr_q[p] + 1'b1;
        if (rd_en[p]) rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
        if (wr_en[p] && !rd_en[p])      count_q[p] <= count_q[p] + 1'b1;
        else if (!wr_en[p] && rd_en[p]) count_q[p] <= count_q[p] - 1'b1;
        cons_q[p] <= cons_d[p];
      end
      if (load) begin
        tvalid_q <= sel_found;
        if (sel_found) begin
          tdata_q <= mem_q[sel_idx][rd_ptr_q[sel_idx]];
          tdest_q <= NUM_PORT_BITS'(sel_idx) + NUM_PORT_BITS'(1);
          rr_q    <= (sel_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      pending_q <= pending_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_q | wr_drop;
      if ((bad_drop || (|wr_drop)) && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign m_axis_tvalid           = tvalid_q;
  assign m_axis_tdata            = tdata_q;
  assign m_axis_tdest            = tdest_q;
  assign dout_leaf_interface2bft = dout_q;
  assign overflow                = ovf_q;
  assign drop_count              = drop_q;

endmodule

// File: tb/tb_bft_host_sink.sv
// Bench for bft_host_sink: directed scenarios plus randomized traffic, checked against
// per-port expected queues and a credit queue derived from consumed-word counts.
module tb_bft_host_sink;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [48:0] din;
  logic [48:0] dout;
  logic [9:0]  cfg_leaf;
  logic [7:0]  cfg_port;
  logic [31:0] tdata;
  logic [3:0]  tdest;
  logic        tvalid;
  logic        tready;
  logic [1:0]  overflow;
  logic [15:0] drop_count;

  bft_host_sink dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .cfg_src_leaf            (cfg_leaf),
    .cfg_src_port            (cfg_port),
    .m_axis_tdata            (tdata),
    .m_axis_tdest            (tdest),
    .m_axis_tvalid           (tvalid),
    .m_axis_tready           (tready),
    .overflow                (overflow),
    .drop_count              (drop_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [48:0] cred_q[$];
  int          exp_drops;
  logic [1:0]  exp_ovf;
  int          fires [NP];
  int          cred_seen;
  int          dest_log[$];
  bit          prev_hold;
  logic [35:0] prev_word;
  int          mon_d;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] credit_pkt(int p);
    return {1'b1, cfg_leaf[(p-1)*5 +: 5], cfg_port[(p-1)*4 +: 4], 7'(p), 32'd64};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din   = '0;
    tick();
    tick();
    exp_q0.delete();
    exp_q1.delete();
    cred_q.delete();
    exp_drops = 0;
    exp_ovf   = '0;
    fires     = '{0, 0};
    cred_seen = 0;
    reset = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_pkt(bit vld, int leaf, int port, logic [31:0] data, bit room);
    din = {vld, 5'(leaf), 4'(port), 7'd0, data};
    if (vld && leaf == 0) begin
      if (port >= 1 && port <= NP) begin
        if (room) begin
          if (port == 1) exp_q0.push_back(data);
          else           exp_q1.push_back(data);
        end else begin
          if (exp_drops < 65535) exp_drops++;
          exp_ovf[port-1] = 1'b1;
        end
      end else if (exp_drops < 65535) begin
        exp_drops++;
      end
    end
    tick();
    din = '0;
  endtask

  task automatic drain(int budget);
    tready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      tick();
    end
    repeat (6) tick();
    check("drain_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    check("credits_drained", 64'(cred_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(tvalid), 64'd1);
        check("hold_word", 64'({tdest, tdata}), 64'(prev_word));
      end
      if (tvalid && tready) begin
        mon_d = int'(tdest);
        dest_log.push_back(mon_d);
        if (mon_d == 1 && exp_q0.size() > 0)      check("data_p1", 64'(tdata), 64'(exp_q0.pop_front()));
        else if (mon_d == 2 && exp_q1.size() > 0) check("data_p2", 64'(tdata), 64'(exp_q1.pop_front()));
        else check("unexpected_fire", 64'({tdest, tdata}), 64'hFFFF_FFFF_FFFF_FFFF);
        if (mon_d == 1 || mon_d == 2) begin
          fires[mon_d-1]++;
          if (fires[mon_d-1] % 64 == 0) cred_q.push_back(credit_pkt(mon_d));
        end
      end
      prev_hold = tvalid && !tready;
      prev_word = {tdest, tdata};
      if (dout !== '0) begin
        cred_seen++;
        if (cred_q.size() > 0) check("credit_pkt", 64'(dout), 64'(cred_q.pop_front()));
        else                   check("spurious_credit", 64'(dout), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic random_phase(int cycles);
    int sent [NP];
    int leaf;
    int port;
    sent = '{0, 0};
    for (int c = 0; c < cycles; c++) begin
      tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end else begin
        leaf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 31)) : 0;
        port = $urandom_range(0, 3);
        if (leaf == 0 && port >= 1 && port <= NP) begin
          if (sent[port-1] >= 120) leaf = 9;
          else sent[port-1]++;
        end
        drive_pkt($urandom_range(0, 7) != 0 || leaf != 0, leaf, port, $urandom, 1'b1);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    din      = '0;
    tready   = 1'b0;
    cfg_leaf = {5'd3, 5'd7};
    cfg_port = {4'd2, 4'd1};
    do_reset();

    // reset state
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tdest", 64'(tdest), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);

    // latency and in-order delivery on port 1
    tready = 1'b1;
    drive_pkt(1'b1, 0, 1, 32'h11, 1'b1);
    check("lat_n1_tvalid", 64'(tvalid), 64'd0);
    drive_pkt(1'b1, 0, 1, 32'h22, 1'b1);
    check("lat_n2_tvalid", 64'(tvalid), 64'd1);
    check("lat_n2_tdata", 64'(tdata), 64'h11);
    check("lat_n2_tdest", 64'(tdest), 64'd1);
    drive_pkt(1'b1, 0, 1, 32'h33, 1'b1);
    check("seq_n3_tdata", 64'(tdata), 64'h22);
    tick();
    check("seq_n4_tdata", 64'(tdata), 64'h33);
    tick();
    check("seq_n5_tvalid", 64'(tvalid), 64'd0);

    // round-robin between ports 1 and 2
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pkt(1'b1, 0, 1, 32'hA000 + i, 1'b1);
      drive_pkt(1'b1, 0, 2, 32'hB000 + i, 1'b1);
    end
    tick();
    dest_log.delete();
    drain(40);
    check("rr_count", 64'(dest_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < dest_log.size(); i++) check("rr_dest", 64'(dest_log[i]), 64'((i % 2) + 1));

    // hold under backpressure, then overflow of port 1
    do_reset();
    tready = 1'b0;
    drive_pkt(1'b1, 0, 2, 32'hA5, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_tvalid", 64'(tvalid), 64'd1);
      check("hold_tdata", 64'(tdata), 64'hA5);
      check("hold_tdest", 64'(tdest), 64'd2);
      tick();
    end
    for (int i = 0; i < 130; i++) drive_pkt(1'b1, 0, 1, 32'h1000 + i, i < 128);
    check("ovf_flag", 64'(overflow), 64'(exp_ovf));
    check("ovf_flag_const", 64'(overflow), 64'b01);
    check("ovf_drops", 64'(drop_count), 64'd2);
    dest_log.delete();
    drain(300);
    check("a5_once", 64'(fires[1]), 64'd1);
    check("ovf_fires_p1", 64'(fires[0]), 64'd128);
    check("ovf_sticky", 64'(overflow), 64'b01);
    check("ovf_credits", 64'(cred_seen), 64'd2);

    // credit return: 128 words on port 1, 64 on port 2
    do_reset();
    for (int i = 0; i < 192; i++) begin
      tready = ($urandom_range(0, 7) != 0);
      if (i < 128) drive_pkt(1'b1, 0, (i % 2) + 1, $urandom, 1'b1);
      else         drive_pkt(1'b1, 0, 1, $urandom, 1'b1);
    end
    drain(300);
    check("credit_count", 64'(cred_seen), 64'd3);
    check("credit_drop", 64'(drop_count), 64'd0);

    // foreign leaf ignored, bad port dropped
    do_reset();
    tready = 1'b1;
    drive_pkt(1'b1, 4, 1, 32'hDEAD, 1'b1);
    tick();
    check("leaf4_nodrop", 64'(drop_count), 64'd0);
    drive_pkt(1'b1, 0, 0, 32'hBEEF, 1'b1);
    check("port0_drop", 64'(drop_count), 64'd1);
    drive_pkt(1'b1, 0, 3, 32'hCAFE, 1'b1);
    check("port3_drop", 64'(drop_count), 64'(exp_drops));
    tick();
    check("bad_no_output", 64'(tvalid), 64'd0);
    check("bad_overflow", 64'(overflow), 64'd0);

    // reset mid-operation
    tready = 1'b0;
    drive_pkt(1'b1, 0, 1, 32'h77, 1'b1);
    drive_pkt(1'b1, 0, 2, 32'h88, 1'b1);
    check("pre_reset_valid", 64'(tvalid), 64'd1);
    reset = 1'b1;
    tick();
    check("midrst_tvalid", 64'(tvalid), 64'd0);
    check("midrst_tdata", 64'(tdata), 64'd0);
    check("midrst_dout", 64'(dout), 64'd0);
    do_reset();
    tready = 1'b1;
    repeat (3) tick();
    check("midrst_discard", 64'(tvalid), 64'd0);

    // randomized traffic
    for (int r = 0; r < 2; r++) begin
      cfg_leaf = 10'($urandom);
      cfg_port = 8'($urandom);
      do_reset();
      random_phase(300);
      drain(400);
      check("rand_drop", 64'(drop_count), 64'(exp_drops));
      check("rand_overflow", 64'(overflow), 64'(exp_ovf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bft_host_sink.md
Name: bft_host_sink

Overview:
- Egress endpoint on the BFT network, directly downstream of a leaf's dout_leaf_interface2bft.
- Accepts 49-bit data packets addressed to its own leaf, buffers them per destination port, and drains them round-robin onto a single AXI-Stream master toward the host DMA.
- Returns freespace (credit) packets to each upstream producer leaf, so producers never overrun the buffers.

Parameters:
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, payload width
- NUM_LEAF_BITS, 5, leaf address width
- NUM_PORT_BITS, 4, port address width
- NUM_ADDR_BITS, 7, address/aux field width
- NUM_PORTS, 2, sink ports; BFT port p (1..NUM_PORTS) maps to FIFO p-1
- FIFO_DEPTH_BITS, 7, log2 of per-port FIFO depth (128 words)
- FREESPACE_UPDATE_SIZE, 64, words consumed per credit packet
- SELF_LEAF, 0, this endpoint's leaf address

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- din_leaf_bft2interface  in  PACKET_BITS  packets from BFT
- dout_leaf_interface2bft  out  PACKET_BITS  credit packets to BFT
- cfg_src_leaf  in  NUM_PORTS*NUM_LEAF_BITS  producer leaf per port, port 1 in LSBs
- cfg_src_port  in  NUM_PORTS*NUM_PORT_BITS  producer output port per port
- m_axis_tdata  out  PAYLOAD_BITS  stream data
- m_axis_tdest  out  NUM_PORT_BITS  originating BFT port (1..NUM_PORTS)
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- overflow  out  NUM_PORTS  sticky per-port overflow flag
- drop_count  out  16  saturating count of dropped packets

Behaviour:
- Packet format:
  - [48] valid
  - [47:43] leaf
  - [42:39] port
  - [38:32] addr
  - [31:0] payload
- Reset: all FIFOs empty, consumed counters 0, pending flags 0, RR pointer 0, m_axis_tvalid=0, tdata/tdest=0, dout_leaf_interface2bft=0, overflow=0, drop_count=0.
- Ingress:
  - A packet is accepted when [48]=1, leaf==SELF_LEAF and 1<=port<=NUM_PORTS.
  - Valid packets for other leaves are ignored, with no count.
  - Valid packets for this leaf with port 0 or port>NUM_PORTS are dropped and drop_count increments.
- Full FIFO:
  - Fullness is judged on the occupancy at the start of the cycle.
  - A write to a full FIFO is dropped even if a read from that FIFO occurs in the same cycle.
  - The drop sets overflow[p-1] (sticky until reset) and increments drop_count.
  - drop_count saturates at 16'hFFFF.
- Write/read same FIFO same cycle: both take effect; occupancy is unchanged.
- Output register:
  - When the output register is empty, or is firing (tvalid&tready), the arbiter selects the next non-empty FIFO in round-robin order, starting after the last granted port.
  - It pops one word into tdata and sets tdest=port.
  - If no FIFO is non-empty, tvalid deasserts after the fire.
- AXI hold: tdata/tdest are held stable while tvalid=1 and tready=0.
- Latency: a packet on input in cycle N is written at edge N+1; with the output idle, tvalid=1 from cycle N+2.
- Fire: a fire on port p increments consumed[p-1].
- Credit trigger:
  - When consumed[p-1] reaches FREESPACE_UPDATE_SIZE, it is reduced by FREESPACE_UPDATE_SIZE and pending[p-1] is set.
  - A fire in the same cycle still counts.
- Credit emission:
  - Each cycle, the lowest-index pending port emits one credit packet for exactly one cycle, then its flag clears.
  - Packet fields: [48]=1, leaf=cfg_src_leaf[p-1], port=cfg_src_port[p-1], addr=p zero-extended, payload=FREESPACE_UPDATE_SIZE.
  - Otherwise dout_leaf_interface2bft=0.
- Reset mid-operation: buffered words and pending credits are discarded; the output drops to 0 on the next cycle.

Test Plan:
- Reset then 3 packets to leaf 0, port 1, payloads 0x11/0x22/0x33, tready=1 -> tvalid first at cycle N+2; tdata 0x11,0x22,0x33 on consecutive cycles; tdest=1.
- Interleaved writes to ports 1 and 2 (4 words each), tready=1 -> output alternates tdest 1,2,1,2...; order within each port preserved.
- tready=0 for 10 cycles while the word 0xA5 is presented -> tdata/tdest stay constant; 0xA5 emitted exactly once after tready=1.
- 130 packets to port 1 with tready=0 -> first 128 buffered; overflow=2'b01; drop_count=2; 128 words later drained intact.
- Stream 128 words on port 1 and 64 on port 2, with cfg_src_leaf={5'd3,5'd7} and cfg_src_port={4'd2,4'd1} -> two credit packets to leaf 7/port 1 (addr=1, payload=64) and one to leaf 3/port 2 (addr=2); simultaneous triggers emit port 1 then port 2 on consecutive cycles.
- Packets to leaf 4 and to leaf 0/port 0 -> leaf 4 ignored with drop_count unchanged; port 0 increments drop_count; no output.
